// File: rtl/wb_stream_checker.sv
// Writeback stream checker: captures retired (rd, data) writes into a small FIFO and
// compares them in order against a preloaded table. Optional macro: WB_CHECK_STOP_ON_ERR_EN.
module wb_stream_checker #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024,
    parameter int LEN_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_we,
    input  logic [$clog2(DEPTH)-1:0]  ld_addr,
    input  logic [REG_W+DATA_W-1:0]   ld_data,
    input  logic [LEN_W-1:0]          exp_len,
    input  logic                      start,
    input  logic                      wb_valid,
    input  logic [REG_W-1:0]          wb_rd,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      wb_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [LEN_W-1:0]          err_count,
    output logic [LEN_W-1:0]          first_err_idx,
    output logic                      extra
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int EW = REG_W + DATA_W;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] ALL_ONES = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
    localparam logic [FW:0]      FULL_CNT = (FW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    logic [EW-1:0] tbl_mem  [DEPTH];
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];

    state_t            state_q, state_d;
    logic [FW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW:0]       cnt_q, cnt_d;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic              pass_q, pass_d, timeout_q, timeout_d, extra_q, extra_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d, err_q, err_d, first_q, first_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              push_s, pop_s, cmp_s, mism_s, flush_s;
    logic [EW-1:0]     head_s, exp_s;

    // Next-state logic for the FIFO, run FSM and result registers.
    always_comb begin
        push_s  = wb_valid && ready_q && (wb_rd != {REG_W{1'b0}});
        pop_s   = (cnt_q != {(FW+1){1'b0}}) && ((state_q == S_RUN) || (state_q == S_DONE));
        cmp_s   = pop_s && (state_q == S_RUN);
        head_s  = fifo_mem[rd_ptr_q];
        exp_s   = tbl_mem[idx_q[AW-1:0]];
        mism_s  = cmp_s && (head_s != exp_s);
        flush_s = start && (state_q != S_RUN);

        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        err_d     = err_q;
        first_d   = first_q;
        idle_d    = idle_q;
        timeout_d = timeout_q;
        extra_d   = extra_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d     = (exp_len > DEPTH_L) ? DEPTH_L : exp_len;
                    idx_d     = {LEN_W{1'b0}};
                    err_d     = {LEN_W{1'b0}};
                    first_d   = ALL_ONES;
                    idle_d    = {TW{1'b0}};
                    timeout_d = 1'b0;
                    extra_d   = 1'b0;
                    state_d   = (exp_len == {LEN_W{1'b0}}) ? S_DONE : S_RUN;
                end else if ((state_q == S_DONE) && pop_s) begin
                    extra_d = 1'b1;
                end else begin
                    extra_d = extra_q;
                end
            end
            S_RUN: begin
                if (cmp_s) begin
                    idle_d = {TW{1'b0}};
                    idx_d  = idx_q + LEN_W'(1);
                    if (mism_s) begin
                        err_d   = (err_q == ALL_ONES) ? err_q : err_q + LEN_W'(1);
                        first_d = (first_q == ALL_ONES) ? idx_q : first_q;
                    end else begin
                        err_d   = err_q;
                    end
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
`ifdef WB_CHECK_STOP_ON_ERR_EN
                        state_d = mism_s ? S_DONE : S_RUN;
`else
                        state_d = S_RUN;
`endif
                    end
                end else if (idle_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A start from IDLE/DONE discards anything still queued, including a same-cycle push.
        if (flush_s) begin
            wr_ptr_d = {FW{1'b0}};
            rd_ptr_d = {FW{1'b0}};
            cnt_d    = {(FW+1){1'b0}};
        end else begin
            wr_ptr_d = push_s ? wr_ptr_q + FW'(1) : wr_ptr_q;
            rd_ptr_d = pop_s  ? rd_ptr_q + FW'(1) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + (FW+1)'(1);
                2'b01:   cnt_d = cnt_q - (FW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        ready_d = (cnt_d != FULL_CNT);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
        pass_d  = (state_d == S_DONE) && (err_d == {LEN_W{1'b0}}) && !timeout_d;
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= {FW{1'b0}};
            rd_ptr_q  <= {FW{1'b0}};
            cnt_q     <= {(FW+1){1'b0}};
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            extra_q   <= 1'b0;
            len_q     <= {LEN_W{1'b0}};
            idx_q     <= {LEN_W{1'b0}};
            err_q     <= {LEN_W{1'b0}};
            first_q   <= ALL_ONES;
            idle_q    <= {TW{1'b0}};
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            extra_q   <= extra_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            first_q   <= first_d;
            idle_q    <= idle_d;
        end
    end

    // Storage arrays; the table survives reset so a rerun needs no reload.
    always_ff @(posedge clk) begin
        if (ld_we && (state_q == S_IDLE)) begin
            tbl_mem[ld_addr] <= ld_data;
        end
        if (push_s && !flush_s) begin
            fifo_mem[wr_ptr_q] <= {wb_rd, wb_data};
        end
    end

    assign wb_ready      = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign extra         = extra_q;
endmodule
